// File: rtl/barker11_pkg.sv
// Shared constants, state encoding and helpers for the Barker-11 chip sequencer.
package barker11_pkg;

  localparam int              NUM_CHIPS   = 11;
  localparam logic [3:0]      LAST_CHIP   = 4'(NUM_CHIPS - 1);
  localparam int              DW_DEFAULT  = 4;
  // MSB is chip 0; a 1 bit is a +1 chip.
  localparam logic [NUM_CHIPS-1:0] BARKER_CODE = 11'b11100010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter width for a count of n cycles, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Value of chip idx (0 = first chip sent) taken from an MSB-first code word.
  function automatic logic barker_chip(input logic [NUM_CHIPS-1:0] code,
                                       input logic [3:0]           idx);
    logic [3:0] pos;
    pos = LAST_CHIP - idx;
    return code[pos];
  endfunction

endpackage

// File: rtl/barker11_chip_timer.sv
// Shared chip/gap down-counter. A load starts a new interval; last is high on
// the final cycle of the interval (count == 0).
module barker11_chip_timer
  import barker11_pkg::*;
#(
  parameter int CHIP_LEN = 64,
  parameter int GAP_LEN  = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic load_chip,
  input  logic load_gap,
  input  logic clear,
  output logic last
);

  localparam int CW = (cnt_width(CHIP_LEN) > cnt_width(GAP_LEN)) ?
                      cnt_width(CHIP_LEN) : cnt_width(GAP_LEN);
  localparam logic [CW-1:0] CHIP_RELOAD = CW'(CHIP_LEN - 1);
  localparam logic [CW-1:0] GAP_RELOAD  = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

  logic [CW-1:0] cnt;

  // Reload on the cycle before an interval begins, otherwise count down to 0.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load_chip) begin
      cnt <= CHIP_RELOAD;
    end else if (load_gap) begin
      cnt <= GAP_RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/barker11_seq.sv
// Barker-11 chip sequencer feeding the PWM modulator: steps through the code,
// swapping the low/high duty codes on -1 chips, with optional repeated bursts.
module barker11_seq
  import barker11_pkg::*;
#(
  parameter int                   CHIP_LEN = 64,
  parameter int                   GAP_LEN  = 128,
  parameter int                   DW       = DW_DEFAULT,
  parameter logic [NUM_CHIPS-1:0] BARKER   = BARKER_CODE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    repeat_n,
  input  logic [DW-1:0] duty_a,
  input  logic [DW-1:0] duty_b,
  output logic [DW-1:0] in0_o,
  output logic [DW-1:0] in1_o,
  output logic          chip,
  output logic [3:0]    chip_idx,
  output logic          chip_stb,
  output logic          busy,
  output logic          done
);

  localparam logic FIRST_CHIP = BARKER[NUM_CHIPS-1];

  state_t        state;
  logic [DW-1:0] duty_a_q;
  logic [DW-1:0] duty_b_q;
  logic [3:0]    repeat_q;
  logic [3:0]    burst_cnt;
  logic [3:0]    burst_nxt;
  logic [3:0]    idx_nxt;
  logic          nxt_chip;
  logic          start_ok;
  logic          burst_end;
  logic          run_done;
  logic          timer_last;
  logic          load_chip;
  logic          load_gap;
  logic          timer_clear;

  assign start_ok  = start && !stop;
  assign burst_nxt = burst_cnt + 4'd1;
  assign idx_nxt   = chip_idx + 4'd1;
  assign nxt_chip  = barker_chip(BARKER, idx_nxt);
  assign burst_end = (state == RUN) && timer_last && (chip_idx == LAST_CHIP);
  assign run_done  = burst_end && (repeat_q != 4'd0) && (burst_nxt == repeat_q);

  barker11_chip_timer #(
    .CHIP_LEN (CHIP_LEN),
    .GAP_LEN  (GAP_LEN)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_chip (load_chip),
    .load_gap  (load_gap),
    .clear     (timer_clear),
    .last      (timer_last)
  );

  // Decide which interval the timer starts next, one cycle ahead of the FSM.
  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    load_chip   = 1'b0;
    load_gap    = 1'b0;
    timer_clear = 1'b0;
    unique case (state)
      IDLE: load_chip = start_ok;
      RUN: begin
        if (stop || run_done)              timer_clear = 1'b1;
        else if (burst_end && GAP_LEN > 0) load_gap    = 1'b1;
        else if (timer_last)               load_chip   = 1'b1;
      end
      GAP: begin
        if (stop)            timer_clear = 1'b1;
        else if (timer_last) load_chip   = 1'b1;
      end
      default: timer_clear = 1'b1;
    endcase
  end

  // Sequencer FSM with registered modulator codes and status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      duty_a_q  <= '0;
      duty_b_q  <= '0;
      repeat_q  <= '0;
      burst_cnt <= '0;
      in0_o     <= '0;
      in1_o     <= '0;
      chip      <= 1'b0;
      chip_idx  <= '0;
      chip_stb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      chip_stb <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && (stop || run_done)) begin
        // Abort or normal end: quiet the modulator; only a normal end reports done.
        state     <= IDLE;
        burst_cnt <= '0;
        in0_o     <= '0;
        in1_o     <= '0;
        chip      <= 1'b0;
        chip_idx  <= '0;
        busy      <= 1'b0;
        done      <= !stop;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_ok) begin
              duty_a_q  <= duty_a;
              duty_b_q  <= duty_b;
              repeat_q  <= repeat_n;
              burst_cnt <= '0;
              state     <= RUN;
              busy      <= 1'b1;
              chip      <= FIRST_CHIP;
              chip_idx  <= '0;
              chip_stb  <= 1'b1;
              in0_o     <= FIRST_CHIP ? duty_a : duty_b;
              in1_o     <= FIRST_CHIP ? duty_b : duty_a;
            end
          end
          RUN: begin
            if (burst_end) begin
              burst_cnt <= burst_nxt;
              chip_idx  <= '0;
              if (GAP_LEN == 0) begin
                chip     <= FIRST_CHIP;
                chip_stb <= 1'b1;
                in0_o    <= FIRST_CHIP ? duty_a_q : duty_b_q;
                in1_o    <= FIRST_CHIP ? duty_b_q : duty_a_q;
              end else begin
                state <= GAP;
                chip  <= 1'b0;
                in0_o <= '0;
                in1_o <= '0;
              end
            end else if (timer_last) begin
              chip_idx <= idx_nxt;
              chip     <= nxt_chip;
              chip_stb <= 1'b1;
              in0_o    <= nxt_chip ? duty_a_q : duty_b_q;
              in1_o    <= nxt_chip ? duty_b_q : duty_a_q;
            end
          end
          GAP: begin
            if (timer_last) begin
              state    <= RUN;
              chip     <= FIRST_CHIP;
              chip_idx <= '0;
              chip_stb <= 1'b1;
              in0_o    <= FIRST_CHIP ? duty_a_q : duty_b_q;
              in1_o    <= FIRST_CHIP ? duty_b_q : duty_a_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_barker11_seq.sv
// Scoreboard bench for barker11_seq: a cycle-level reference model pushes the
// expected output word per clock; a monitor pops and compares on each falling edge.
module tb_barker11_seq;

  localparam int CL     = 4;
  localparam int GL     = 2;
  localparam int DW     = 4;
  localparam int BURST  = 11 * CL;
  localparam int PERIOD = BURST + GL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [3:0]    repeat_n = '0;
  logic [DW-1:0] duty_a = '0;
  logic [DW-1:0] duty_b = '0;
  logic [DW-1:0] in0_o;
  logic [DW-1:0] in1_o;
  logic          chip;
  logic [3:0]    chip_idx;
  logic          chip_stb;
  logic          busy;
  logic          done;

  barker11_seq #(
    .CHIP_LEN (CL),
    .GAP_LEN  (GL),
    .DW       (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .repeat_n (repeat_n),
    .duty_a   (duty_a),
    .duty_b   (duty_b),
    .in0_o    (in0_o),
    .in1_o    (in1_o),
    .chip     (chip),
    .chip_idx (chip_idx),
    .chip_stb (chip_stb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Output word layout: {in0[15:12], in1[11:8], chip[7], idx[6:3], stb[2], busy[1], done[0]}
  logic [15:0] act_vec;
  assign act_vec = {in0_o, in1_o, chip, chip_idx, chip_stb, busy, done};

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          stb_seen = 0;
  int          done_seen = 0;

  // Barker-11 sequence as signed chips, chip 0 first.
  int code[11] = '{1, 1, 1, -1, -1, -1, 1, -1, -1, 1, -1};

  // Reference model state: is a run active, cycles since the start edge, latched inputs.
  logic          rst_req = 1'b1;
  bit            m_active = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;
  int            m_rep = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge
  // and queue the outputs expected after it.
  task automatic model_step();
    logic [15:0] e;
    int pos;
    int k;
    e = '0;
    if (rst_req) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1'b1;
        m_t      = 1;
        m_a      = duty_a;
        m_b      = duty_b;
        m_rep    = int'(repeat_n);
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else begin
      m_t++;
    end
    if (m_active) begin
      if (m_rep != 0 && m_t == m_rep * PERIOD - GL + 1) begin
        e[0]     = 1'b1;
        m_active = 1'b0;
      end else begin
        pos  = (m_t - 1) % PERIOD;
        e[1] = 1'b1;
        if (pos < BURST) begin
          k        = pos / CL;
          e[2]     = (pos % CL == 0);
          e[6:3]   = 4'(k);
          e[7]     = (code[k] > 0);
          e[15:12] = (code[k] > 0) ? m_a : m_b;
          e[11:8]  = (code[k] > 0) ? m_b : m_a;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock: reset changes land mid-cycle after the monitor's sample, other
  // inputs were driven just after the previous rising edge.
  task automatic step();
    @(negedge clk);
    #1;
    rst = rst_req;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs with the queued expectation every cycle.
  initial begin
    int cyc;
    logic [15:0] e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle %0d outputs", cyc), {16'h0, act_vec}, {16'h0, e});
        if (chip_stb) stb_seen++;
        if (done) done_seen++;
      end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int s0;
    int d0;
    bit hit;

    // Reset held, then released into IDLE.
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    repeat (3) step();

    // Single burst; start re-pulsed and duty codes changed mid-burst.
    s0 = stb_seen;
    d0 = done_seen;
    duty_a = 4'd3; duty_b = 4'd5; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      if (i >= 20) begin
        duty_a = 4'd9; duty_b = 4'd12; repeat_n = 4'd7;
      end
      step();
    end
    start = 1'b0;
    check("single burst chip_stb count", stb_seen - s0, 11);
    check("single burst done count", done_seen - d0, 1);

    // Two bursts with a gap between them.
    s0 = stb_seen;
    d0 = done_seen;
    duty_a = 4'd6; duty_b = 4'd1; repeat_n = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    check("two burst chip_stb count", stb_seen - s0, 22);
    check("two burst done count", done_seen - d0, 1);

    // Continuous mode, stopped during the gap after the fifth burst.
    s0 = stb_seen;
    d0 = done_seen;
    duty_a = 4'd2; duty_b = 4'd13; repeat_n = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_active && m_t > 4 * PERIOD && ((m_t - 1) % PERIOD) >= BURST) hit = 1'b1;
      else step();
    end
    check("continuous run reached fifth gap", 32'(hit), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (5) step();
    check("continuous chip_stb count", stb_seen - s0, 55);
    check("continuous done count", done_seen - d0, 0);

    // start and stop together in IDLE: nothing starts.
    start = 1'b1; stop = 1'b1; repeat_n = 4'd1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (3) step();

    // Reset in the middle of chip 5, then a fresh run from chip 0.
    duty_a = 4'd10; duty_b = 4'd4; repeat_n = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_active && (m_t - 1) / CL == 5 && (m_t - 1) % CL == 1) hit = 1'b1;
      else step();
    end
    check("reached chip 5 before reset", 32'(hit), 1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    d0 = done_seen;
    duty_a = 4'd7; duty_b = 4'd8; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    check("restart after reset done count", done_seen - d0, 1);

    // Randomized runs with noisy inputs, stray starts and occasional stops.
    for (int r = 0; r < 6; r++) begin
      repeat_n = 4'($urandom_range(0, 3));
      duty_a   = DW'($urandom);
      duty_b   = DW'($urandom);
      start    = 1'b1;
      step();
      for (int i = 0; i < 160; i++) begin
        start    = ($urandom_range(0, 7) == 0);
        stop     = ($urandom_range(0, 99) == 0);
        duty_a   = DW'($urandom);
        duty_b   = DW'($urandom);
        repeat_n = 4'($urandom);
        step();
      end
      start = 1'b0;
      stop  = 1'b1;
      step();
      stop = 1'b0;
    end

    @(negedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
